// File: rtl/alu_operand_stage_pkg.sv
// Shared types and constants for the ALU operand stage: opcodes, width defaults and the
// forward-select enum.
package alu_operand_stage_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned RADDR_W_DEF = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

endpackage

// File: rtl/alu_operand_stage_operand_fwd_sel.sv
// Resolves one source register against the EX, MEM and WB writers: select, forwarded value,
// load-use flag and an any-writer hit flag.
module operand_fwd_sel
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF
) (
    input  logic [RADDR_W-1:0] rs,
    input  logic [XLEN-1:0]    rf_data,
    input  logic               ex_valid,
    input  logic               ex_reg_write,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]    ex_data,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_data,
    input  logic               mem_is_load,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output fwd_sel_e           sel,
    output logic [XLEN-1:0]    value,
    output logic               load_use,
    output logic               hit
);

    logic rs_nz;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // Requiring rs != 0 also keeps an rd = 0 writer from ever matching.
    assign rs_nz   = (rs != '0);
    assign ex_hit  = rs_nz & ex_valid & ex_reg_write & (ex_rd == rs);
    assign mem_hit = rs_nz & mem_reg_write & (mem_rd == rs);
    assign wb_hit  = rs_nz & wb_reg_write & (wb_rd == rs);

    assign load_use = mem_hit & mem_is_load;
    assign hit      = ex_hit | mem_hit | wb_hit;

    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        value = rf_data;
        unique case (sel)
            FWD_RF:  value = rf_data;
            FWD_EX:  value = ex_data;
            FWD_MEM: value = mem_data;
            FWD_WB:  value = wb_data;
        endcase
        if (!rs_nz) begin
            value = '0;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage in front of the ALU: captures decode, resolves operands, detects RAW hazards.
// Define ALU_OPERAND_FORWARD_EN to build forwarding; otherwise any writer match stalls.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [RADDR_W-1:0] dec_rs1,
    input  logic [RADDR_W-1:0] dec_rs2,
    input  logic [XLEN-1:0]    dec_rs1_data,
    input  logic [XLEN-1:0]    dec_rs2_data,
    input  logic [XLEN-1:0]    dec_imm,
    input  logic               dec_use_imm,
    input  logic [3:0]         dec_alu_control,
    input  logic [RADDR_W-1:0] dec_rd,
    input  logic               dec_reg_write,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [XLEN-1:0]    alu_in1,
    output logic [XLEN-1:0]    alu_in2,
    output logic [3:0]         alu_control,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write,
    input  logic [XLEN-1:0]    ex_alu_result,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_data,
    input  logic               mem_is_load,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data
);

    logic               ex_valid_q;
    logic [XLEN-1:0]    alu_in1_q, alu_in2_q, store_data_q;
    logic [3:0]         alu_control_q;
    logic [RADDR_W-1:0] ex_rd_q;
    logic               ex_reg_write_q;

    fwd_sel_e           rs1_sel, rs2_sel;
    logic [XLEN-1:0]    rs1_fwd, rs2_fwd;
    logic               rs1_load_use, rs2_load_use;
    logic               rs1_hit, rs2_hit;

    logic [XLEN-1:0]    rs1_val, rs2_val;
    logic               hazard;
    logic               fire;

    operand_fwd_sel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_rs1_sel (
        .rs            (dec_rs1),
        .rf_data       (dec_rs1_data),
        .ex_valid      (ex_valid_q),
        .ex_reg_write  (ex_reg_write_q),
        .ex_rd         (ex_rd_q),
        .ex_data       (ex_alu_result),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_is_load   (mem_is_load),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .sel           (rs1_sel),
        .value         (rs1_fwd),
        .load_use      (rs1_load_use),
        .hit           (rs1_hit)
    );

    operand_fwd_sel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_rs2_sel (
        .rs            (dec_rs2),
        .rf_data       (dec_rs2_data),
        .ex_valid      (ex_valid_q),
        .ex_reg_write  (ex_reg_write_q),
        .ex_rd         (ex_rd_q),
        .ex_data       (ex_alu_result),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_is_load   (mem_is_load),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .sel           (rs2_sel),
        .value         (rs2_fwd),
        .load_use      (rs2_load_use),
        .hit           (rs2_hit)
    );

`ifdef ALU_OPERAND_FORWARD_EN
    logic unused_fwd;
    assign unused_fwd = ^{rs1_sel, rs2_sel, rs1_hit, rs2_hit};

    assign rs1_val = rs1_fwd;
    assign rs2_val = rs2_fwd;
    assign hazard  = rs1_load_use | (rs2_load_use & ~dec_use_imm);
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs1_sel, rs2_sel, rs1_fwd, rs2_fwd, rs1_load_use, rs2_load_use};

    // Without forwarding the register file is trusted only once no writer is in flight.
    assign rs1_val = (dec_rs1 == '0) ? '0 : dec_rs1_data;
    assign rs2_val = (dec_rs2 == '0) ? '0 : dec_rs2_data;
    assign hazard  = rs1_hit | (rs2_hit & ~dec_use_imm);
`endif

    assign dec_ready = flush | ((~ex_valid_q | ex_ready) & ~hazard);
    assign fire      = dec_valid & dec_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            alu_in1_q      <= '0;
            alu_in2_q      <= '0;
            store_data_q   <= '0;
            alu_control_q  <= ALU_ADD;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
        end else begin
            if (flush) begin
                ex_valid_q <= 1'b0;
            end else if (fire) begin
                ex_valid_q <= 1'b1;
            end else if (ex_ready) begin
                ex_valid_q <= 1'b0;
            end

            if (fire) begin
                alu_in1_q      <= rs1_val;
                alu_in2_q      <= dec_use_imm ? dec_imm : rs2_val;
                store_data_q   <= rs2_val;
                alu_control_q  <= dec_alu_control;
                ex_rd_q        <= dec_rd;
                ex_reg_write_q <= dec_reg_write;
            end
        end
    end

    assign ex_valid      = ex_valid_q;
    assign alu_in1       = alu_in1_q;
    assign alu_in2       = alu_in2_q;
    assign ex_store_data = store_data_q;
    assign alu_control   = alu_control_q;
    assign ex_rd         = ex_rd_q;
    assign ex_reg_write  = ex_reg_write_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; forwarding-dependent expectations follow
// ALU_OPERAND_FORWARD_EN.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [31:0] dec_rs1_data, dec_rs2_data, dec_imm;
    logic        dec_use_imm;
    logic [3:0]  dec_alu_control;
    logic        dec_reg_write;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic [31:0] ex_alu_result;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_is_load;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks   = 0;
    int failures = 0;

    alu_operand_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_rs1         (dec_rs1),
        .dec_rs2         (dec_rs2),
        .dec_rs1_data    (dec_rs1_data),
        .dec_rs2_data    (dec_rs2_data),
        .dec_imm         (dec_imm),
        .dec_use_imm     (dec_use_imm),
        .dec_alu_control (dec_alu_control),
        .dec_rd          (dec_rd),
        .dec_reg_write   (dec_reg_write),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .alu_in1         (alu_in1),
        .alu_in2         (alu_in2),
        .alu_control     (alu_control),
        .ex_store_data   (ex_store_data),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_alu_result   (ex_alu_result),
        .mem_reg_write   (mem_reg_write),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .mem_is_load     (mem_is_load),
        .wb_reg_write    (wb_reg_write),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        flush         = 1'b0;
        dec_valid     = 1'b0;
        dec_rs1       = '0;
        dec_rs2       = '0;
        dec_rs1_data  = '0;
        dec_rs2_data  = '0;
        dec_imm       = '0;
        dec_use_imm   = 1'b0;
        dec_alu_control = ALU_ADD;
        dec_rd        = '0;
        dec_reg_write = 1'b0;
        ex_ready      = 1'b1;
        ex_alu_result = '0;
        mem_reg_write = 1'b0;
        mem_rd        = '0;
        mem_data      = '0;
        mem_is_load   = 1'b0;
        wb_reg_write  = 1'b0;
        wb_rd         = '0;
        wb_data       = '0;
    endtask

    task automatic drive_dec(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic use_imm,
                             input logic [3:0] ctl, input logic [4:0] rd, input logic rw);
        dec_valid       = 1'b1;
        dec_rs1         = rs1;
        dec_rs2         = rs2;
        dec_rs1_data    = d1;
        dec_rs2_data    = d2;
        dec_imm         = imm;
        dec_use_imm     = use_imm;
        dec_alu_control = ctl;
        dec_rd          = rd;
        dec_reg_write   = rw;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        check({tag, "_in1"}, alu_in1, 32'd0);
        check({tag, "_in2"}, alu_in2, 32'd0);
        check({tag, "_ctl"}, {28'd0, alu_control}, 32'd0);
        check({tag, "_store"}, ex_store_data, 32'd0);
        check({tag, "_rd"}, {27'd0, ex_rd}, 32'd0);
        check({tag, "_rw"}, {31'd0, ex_reg_write}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_cleared("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x3, x1, 5
        @(negedge clk);
        drive_dec(5'd1, 5'd0, 32'd10, 32'd0, 32'd5, 1'b1, ALU_ADD, 5'd3, 1'b1);
        #1 check("addi_rdy", {31'd0, dec_ready}, 32'd1);
        @(posedge clk); #1;
        check("addi_valid", {31'd0, ex_valid}, 32'd1);
        check("addi_in1", alu_in1, 32'd10);
        check("addi_in2", alu_in2, 32'd5);
        check("addi_ctl", {28'd0, alu_control}, 32'd0);
        check("addi_rd", {27'd0, ex_rd}, 32'd3);
        @(negedge clk);
        set_idle();
        @(posedge clk); #1;
        check("drain_valid", {31'd0, ex_valid}, 32'd0);

        // Back-pressure: entry A held for 3 cycles while B waits.
        @(negedge clk);
        drive_dec(5'd8, 5'd9, 32'd100, 32'd200, 32'd0, 1'b0, ALU_ADD, 5'd7, 1'b1);
        @(posedge clk); #1;
        check("bp_a_in1", alu_in1, 32'd100);
        @(negedge clk);
        ex_ready = 1'b0;
        drive_dec(5'd10, 5'd11, 32'h111, 32'h222, 32'd0, 1'b0, ALU_XOR, 5'd12, 1'b1);
        #1 check("bp_rdy0", {31'd0, dec_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_in1", alu_in1, 32'd100);
            check("bp_hold_in2", alu_in2, 32'd200);
            check("bp_hold_valid", {31'd0, ex_valid}, 32'd1);
            check("bp_hold_rd", {27'd0, ex_rd}, 32'd7);
            check("bp_hold_rdy", {31'd0, dec_ready}, 32'd0);
        end
        @(negedge clk);
        ex_ready = 1'b1;
        #1 check("bp_rdy1", {31'd0, dec_ready}, 32'd1);
        @(posedge clk); #1;
        check("bp_b_in1", alu_in1, 32'h111);
        check("bp_b_in2", alu_in2, 32'h222);
        check("bp_b_ctl", {28'd0, alu_control}, {28'd0, ALU_XOR});
        check("bp_b_rd", {27'd0, ex_rd}, 32'd12);

        // Flush together with a valid decode: dropped, not captured.
        @(negedge clk);
        flush = 1'b1;
        drive_dec(5'd13, 5'd14, 32'h55, 32'h66, 32'd0, 1'b0, ALU_SUB, 5'd15, 1'b1);
        #1 check("flush_rdy", {31'd0, dec_ready}, 32'd1);
        @(posedge clk); #1;
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_in1", alu_in1, 32'h111);
        check("flush_rd", {27'd0, ex_rd}, 32'd12);

        // x0 source with rd = 0 writers present.
        @(negedge clk);
        set_idle();
        wb_reg_write  = 1'b1;
        wb_rd         = 5'd0;
        wb_data       = 32'h1234;
        mem_reg_write = 1'b1;
        mem_rd        = 5'd0;
        mem_is_load   = 1'b1;
        mem_data      = 32'h4321;
        drive_dec(5'd0, 5'd0, 32'hFFFF, 32'hFFFF, 32'd7, 1'b1, ALU_ADD, 5'd0, 1'b0);
        #1 check("x0_rdy", {31'd0, dec_ready}, 32'd1);
        @(posedge clk); #1;
        check("x0_in1", alu_in1, 32'd0);
        check("x0_in2", alu_in2, 32'd7);
        check("x0_store", ex_store_data, 32'd0);

        // Load-use: or x6, x5, x0 behind a load to x5.
        @(negedge clk);
        set_idle();
        mem_reg_write = 1'b1;
        mem_rd        = 5'd5;
        mem_is_load   = 1'b1;
        mem_data      = 32'hEE;
        drive_dec(5'd5, 5'd0, 32'h11, 32'h99, 32'd0, 1'b0, ALU_OR, 5'd6, 1'b1);
        #1 check("lu_rdy0", {31'd0, dec_ready}, 32'd0);
        @(posedge clk); #1;
        check("lu_stall_valid", {31'd0, ex_valid}, 32'd0);
        @(negedge clk);
        mem_reg_write = 1'b0;
        mem_is_load   = 1'b0;
        wb_reg_write  = 1'b1;
        wb_rd         = 5'd5;
        wb_data       = 32'hAB;
`ifdef ALU_OPERAND_FORWARD_EN
        #1 check("lu_rdy1", {31'd0, dec_ready}, 32'd1);
`else
        #1 check("wb_stall_rdy", {31'd0, dec_ready}, 32'd0);
        @(negedge clk);
        wb_reg_write = 1'b0;
        dec_rs1_data = 32'hAB;
        #1 check("wb_after_rdy", {31'd0, dec_ready}, 32'd1);
`endif
        @(posedge clk); #1;
        check("lu_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_in1", alu_in1, 32'hAB);
        check("lu_in2", alu_in2, 32'd0);
        check("lu_ctl", {28'd0, alu_control}, {28'd0, ALU_OR});
        check("lu_rd", {27'd0, ex_rd}, 32'd6);

        // Put a writer of x1 into EX.
        @(negedge clk);
        set_idle();
        drive_dec(5'd20, 5'd21, 32'd1, 32'd2, 32'd0, 1'b0, ALU_ADD, 5'd1, 1'b1);
        @(posedge clk); #1;
        check("exw_rd", {27'd0, ex_rd}, 32'd1);

        // sub x4, x1, x2 with EX and MEM both writing x1.
        @(negedge clk);
        set_idle();
        ex_alu_result = 32'h20;
        mem_reg_write = 1'b1;
        mem_rd        = 5'd1;
        mem_data      = 32'h30;
        drive_dec(5'd1, 5'd2, 32'hDEAD, 32'd3, 32'd0, 1'b0, ALU_SUB, 5'd4, 1'b1);
`ifdef ALU_OPERAND_FORWARD_EN
        #1 check("exf_rdy", {31'd0, dec_ready}, 32'd1);
        @(posedge clk); #1;
        check("exf_in1", alu_in1, 32'h20);
        check("exf_in2", alu_in2, 32'd3);
        check("exf_store", ex_store_data, 32'd3);
        // MEM-only match on rs1; rs2 matches EX but uses the immediate.
        @(negedge clk);
        ex_alu_result = 32'h44;
        drive_dec(5'd1, 5'd4, 32'hDEAD, 32'h77, 32'd9, 1'b1, ALU_ADD, 5'd8, 1'b1);
        #1 check("memf_rdy", {31'd0, dec_ready}, 32'd1);
        @(posedge clk); #1;
        check("memf_in1", alu_in1, 32'h30);
        check("memf_in2", alu_in2, 32'd9);
        check("memf_store", ex_store_data, 32'h44);
`else
        #1 check("exm_stall_rdy", {31'd0, dec_ready}, 32'd0);
        @(posedge clk); #1;
        check("exm_stall_valid", {31'd0, ex_valid}, 32'd0);
        // rs2 matches WB but uses the immediate: no stall, rf data for store.
        @(negedge clk);
        set_idle();
        wb_reg_write = 1'b1;
        wb_rd        = 5'd1;
        wb_data      = 32'h99;
        drive_dec(5'd2, 5'd1, 32'd5, 32'h77, 32'd9, 1'b1, ALU_ADD, 5'd8, 1'b1);
        #1 check("imm_rs2_rdy", {31'd0, dec_ready}, 32'd1);
        @(posedge clk); #1;
        check("imm_rs2_in1", alu_in1, 32'd5);
        check("imm_rs2_in2", alu_in2, 32'd9);
        check("imm_rs2_store", ex_store_data, 32'h77);
`endif

        // Asynchronous reset in the middle of a live entry.
        @(negedge clk);
        set_idle();
        drive_dec(5'd3, 5'd4, 32'h1, 32'h2, 32'd0, 1'b0, ALU_XOR, 5'd9, 1'b1);
        @(posedge clk); #1;
        check("mid_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_cleared("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
